// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// Holds the occupancy state encoding, the NOP bubble word and default widths.
package pipe_pkg;

    localparam int unsigned DefDataW = 256;
    localparam int unsigned DefCntW  = 16;
    localparam int unsigned MaxDataW = 1024;

    // Bubble encoding: an all-zero payload decodes as a NOP downstream.
    localparam logic [MaxDataW-1:0] NopWord = '0;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, NOP bubbles and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_valid ? main_q : NopWord[DATA_W-1:0];
    assign level     = 2'(state_q);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // The skid variant breaks the ready path: in_ready depends on state alone.
    if (SKID != 0) begin : g_skid
        assign in_ready = !rst && (state_q != StTwo);
    end else begin : g_pass
        assign in_ready = !rst && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_q  <= in_data;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_q  <= in_data;
                        state_q <= StTwo;
                    end else if (out_xfer) begin
                        main_q  <= '0;
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        state_q <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    main_q  <= '0;
                    skid_q  <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, 3-bit-counter and pass-register builds share
// one input stream and are checked against a FIFO-level reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        ir_s, ov_s, ir_t, ov_t, ir_p, ov_p;
    logic [31:0] od_s, od_t, od_p;
    logic [1:0]  lvl_s, lvl_t, lvl_p;
    logic [15:0] st_s, st_p;
    logic [2:0]  st_t;

    int checks = 0;
    int failures = 0;

    // Reference model: k=0 skid (capacity 2), k=1 pass register (capacity 1).
    logic [31:0] m_buf [2][2];
    int          m_lvl [2];
    int          m_stall [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
        .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
        .level(lvl_s), .stall_cnt(st_s)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_t),
        .in_data(in_data), .out_valid(ov_t), .out_ready(out_ready), .out_data(od_t),
        .level(lvl_t), .stall_cnt(st_t)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_pass (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_p),
        .in_data(in_data), .out_valid(ov_p), .out_ready(out_ready), .out_data(od_p),
        .level(lvl_p), .stall_cnt(st_p)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] d;
        logic        ordy;
        logic        ir, ov;
        logic [31:0] od;
        logic [1:0]  lvl;
        logic [15:0] st;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(int r, int f, int iv, int d, int o,
                                int ir, int ov, int od, int lvl, int st);
        vec_t v;
        v.rst = (r != 0);   v.flush = (f != 0); v.iv = (iv != 0);
        v.d = 32'(d);       v.ordy = (o != 0);  v.ir = (ir != 0);
        v.ov = (ov != 0);   v.od = 32'(od);     v.lvl = 2'(lvl);
        v.st = 16'(st);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input int k, input int unsigned sat,
                           input logic ir, input logic ov, input logic [31:0] od,
                           input logic [1:0] lvl, input logic [31:0] st);
        logic e_ir;
        e_ir = !rst && ((k == 0) ? (m_lvl[0] < 2) : (m_lvl[1] == 0 || out_ready));
        chk({tag, "_in_ready"}, 32'(ir), 32'(e_ir));
        chk({tag, "_out_valid"}, 32'(ov), 32'(m_lvl[k] > 0));
        chk({tag, "_out_data"}, od, (m_lvl[k] > 0) ? m_buf[k][0] : 32'h0);
        chk({tag, "_level"}, 32'(lvl), 32'(m_lvl[k]));
        chk({tag, "_stall_cnt"}, st,
            (m_stall[k] > int'(sat)) ? 32'(sat) : 32'(m_stall[k]));
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic ir, ov;
            ir = !rst && ((k == 0) ? (m_lvl[0] < 2) : (m_lvl[1] == 0 || out_ready));
            ov = (m_lvl[k] > 0);
            if (rst) begin
                m_lvl[k] = 0;
                m_stall[k] = 0;
            end else begin
                if (ov && !out_ready) m_stall[k]++;
                if (flush) begin
                    m_lvl[k] = 0;
                end else begin
                    if (ov && out_ready) begin
                        m_buf[k][0] = m_buf[k][1];
                        m_lvl[k]--;
                    end
                    if (in_valid && ir) begin
                        m_buf[k][m_lvl[k]] = in_data;
                        m_lvl[k]++;
                    end
                end
            end
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check, then advance the model.
    task automatic step(input int r, input int f, input int iv, input int d, input int o);
        @(negedge clk);
        rst = (r != 0); flush = (f != 0); in_valid = (iv != 0);
        in_data = 32'(d); out_ready = (o != 0);
        #1;
        chk_dut("skid", 0, 65535, ir_s, ov_s, od_s, lvl_s, 32'(st_s));
        chk_dut("sat3", 0, 7, ir_t, ov_t, od_t, lvl_t, 32'(st_t));
        chk_dut("pass", 1, 65535, ir_p, ov_p, od_p, lvl_p, 32'(st_p));
        chk("pass_level_max", 32'(lvl_p <= 2'd1), 32'd1);
        model_update();
    endtask

    initial begin
        //            rst fl iv d     or  ir ov od    lvl st
        tbl[0]  = mk(1, 0, 0, 0,    0,  0, 0, 0,    0, 0);
        tbl[1]  = mk(0, 0, 1, 'h11, 0,  1, 0, 0,    0, 0);
        tbl[2]  = mk(0, 0, 1, 'h22, 0,  1, 1, 'h11, 1, 0);
        tbl[3]  = mk(0, 0, 1, 'h99, 0,  0, 1, 'h11, 2, 1);
        tbl[4]  = mk(0, 0, 0, 0,    1,  0, 1, 'h11, 2, 2);
        tbl[5]  = mk(0, 0, 0, 0,    1,  1, 1, 'h22, 1, 2);
        tbl[6]  = mk(0, 0, 0, 0,    1,  1, 0, 0,    0, 2);
        tbl[7]  = mk(0, 0, 1, 'h44, 0,  1, 0, 0,    0, 2);
        tbl[8]  = mk(0, 0, 1, 'h55, 0,  1, 1, 'h44, 1, 2);
        tbl[9]  = mk(0, 1, 1, 'h33, 0,  0, 1, 'h44, 2, 3);
        tbl[10] = mk(0, 0, 0, 0,    1,  1, 0, 0,    0, 4);
        tbl[11] = mk(0, 0, 1, 'h66, 0,  1, 0, 0,    0, 4);
        tbl[12] = mk(0, 1, 1, 'h77, 1,  1, 1, 'h66, 1, 4);
        tbl[13] = mk(0, 0, 0, 0,    1,  1, 0, 0,    0, 4);
        tbl[14] = mk(0, 0, 1, 'hA1, 0,  1, 0, 0,    0, 4);
        tbl[15] = mk(0, 0, 1, 'hA2, 0,  1, 1, 'hA1, 1, 4);
        tbl[16] = mk(1, 0, 1, 'hA3, 0,  0, 1, 'hA1, 2, 5);
        tbl[17] = mk(1, 0, 0, 0,    0,  0, 0, 0,    0, 0);
        tbl[18] = mk(0, 0, 0, 0,    1,  1, 0, 0,    0, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 0; m_stall[k] = 0; m_buf[k][0] = '0; m_buf[k][1] = '0;
        end
        repeat (2) @(posedge clk);

        // Fill/drain, flush in TWO and ONE, reset while full.
        for (int i = 0; i < 19; i++) begin
            step(int'(tbl[i].rst), int'(tbl[i].flush), int'(tbl[i].iv), int'(tbl[i].d),
                 int'(tbl[i].ordy));
            chk($sformatf("tbl%0d_in_ready", i), 32'(ir_s), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(ov_s), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_data", i), od_s, tbl[i].od);
            chk($sformatf("tbl%0d_level", i), 32'(lvl_s), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_stall", i), 32'(st_s), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_sat_stall", i), 32'(st_t), 32'(tbl[i].st));
        end

        // Streaming: beats 1..10 appear one cycle later at constant level 1.
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 1, c + 1, 1);
            if (c > 0) begin
                chk("stream_data", od_s, 32'(c));
                chk("stream_level", 32'(lvl_s), 32'd1);
            end
            chk("stream_stall", 32'(st_s), 32'd0);
        end
        step(0, 0, 0, 0, 1);
        chk("stream_last", od_s, 32'd10);

        // Saturation of the 3-bit counter and SKID=0 ready behaviour.
        step(0, 0, 1, 'hC0, 0);
        repeat (12) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("sat_value", 32'(st_t), 32'd7);
        chk("sat_wide_value", 32'(st_s), 32'd12);
        chk("pass_ready_blocked", 32'(ir_p), 32'd0);
        step(1 - 1, 0, 0, 0, 1);
        chk("sat_held", 32'(st_t), 32'd7);
        chk("pass_ready_open", 32'(ir_p), 32'd1);

        // Randomized traffic against the model.
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            step(int'($urandom_range(199, 0) == 0), int'($urandom_range(99, 0) < 3),
                 int'($urandom_range(99, 0) < 70), int'($urandom),
                 int'($urandom_range(99, 0) < 60));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 256, payload width in bits; legal range 1..1024.
REQ-002 Parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single-entry pass register.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter; legal range 1..32.
REQ-004 The reset is rst, synchronous, active-high, and the clock is clk.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discard all held entries (exception or branch kill).
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_ready  output  1  stage accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  upstream payload (op, operands, address, exception word).
REQ-011 out_valid  output  1  out_data holds a live instruction.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 out_data  output  DATA_W  payload to the next stage; all-zero (NOP) when out_valid=0.
REQ-014 level  output  2  number of held entries, 0..2.
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 An input transfer is in_valid&&in_ready; an output transfer is out_valid&&out_ready.
REQ-017 The state machine has states EMPTY, ONE and TWO; level shall equal 0, 1 or 2 respectively.
REQ-018 EMPTY: an input transfer loads the main register, next state ONE; otherwise hold.
REQ-019 ONE, input and output transfer together: main<=in_data, state stays ONE.
REQ-020 ONE, input transfer only: in_data goes to the skid register, next state TWO (SKID=1 only).
REQ-021 ONE, output transfer only: next state EMPTY.
REQ-022 TWO: in_ready=0; an output transfer moves skid into main, next state ONE.
REQ-023 With SKID=1, in_ready shall be a function of state only (state!=TWO); there is no combinational path from out_ready.
REQ-024 With SKID=0, in_ready=!out_valid||out_ready (combinational), and TWO is unreachable.
REQ-025 Latency: data accepted in cycle N appears on out_data with out_valid=1 in cycle N+1.
REQ-026 Ordering is strictly FIFO; no entry is duplicated or dropped except by flush or rst.
REQ-027 While out_valid=0, out_data shall be all-zero (bubble equals NOP encoding).
REQ-028 out_data shall remain stable while out_valid=1 and out_ready=0.
REQ-029 flush has priority over all transfers: next state EMPTY, main and skid zeroed, a coincident input transfer discarded; stall_cnt unaffected.
REQ-030 stall_cnt increments by 1 in each cycle with out_valid&&!out_ready, saturates at all-ones, and never wraps.

Reset
REQ-031 rst has priority over flush; next state EMPTY, main, skid and stall_cnt cleared to zero.
REQ-032 During and after reset: out_valid=0, out_data=0, level=0, stall_cnt=0; in_ready=0 while rst=1 and 1 in the first cycle after release.
REQ-033 rst asserted mid-transfer discards all held and incoming entries.

Structure
REQ-034 A shared package pipe_pkg shall hold the state enumeration (EMPTY/ONE/TWO), the NOP zero-word constant and the default widths.
REQ-035 The saturating counter shall be a sub-module sat_counter (parameter CNT_W, inputs clk, rst, inc, output count).

Verification
REQ-036 Fill/drain: out_ready=0, push A=0x11, B=0x22 -> level=2, in_ready=0; then out_ready=1 -> A then B on consecutive cycles, level 2->1->0.
REQ-037 Streaming: in_valid=out_ready=1 for 10 beats 1..10 -> out_data 1..10 one cycle later, level constant 1, stall_cnt=0.
REQ-038 Flush in TWO with coincident in_valid=1 data 0x33 -> next cycle level=0, out_valid=0, out_data=0, 0x33 never emitted.
REQ-039 Saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 12 cycles -> stall_cnt=7 and held.
REQ-040 rst pulse while level=2 -> next cycle out_valid=0, stall_cnt=0, in_ready=0; first cycle after release in_ready=1.
REQ-041 SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle; level never exceeds 1.
